// File: rtl/scope_pkg.sv
// Shared types and constants for the multi-channel scope capture engine.
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST_FILL = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/scope_trig_detect.sv
// Edge trigger with hysteresis: a sample must leave the band beyond
// the threshold before a crossing of the threshold counts as a hit.
module scope_trig_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] hyst,
    input  logic              trig_edge,
    input  logic              valid,
    input  logic              clear,
    output logic              hit
);

    logic              armed;
    logic              arm_cond;
    logic              fire_cond;
    logic [DATA_W-1:0] lo_th;
    logic [DATA_W-1:0] hi_th;
    logic [DATA_W:0]   hi_sum;

    assign lo_th  = (level > hyst) ? level - hyst : '0;
    assign hi_sum = {1'b0, level} + {1'b0, hyst};
    assign hi_th  = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];

    always_comb begin
        arm_cond  = 1'b0;
        fire_cond = 1'b0;
        if (trig_edge == EDGE_FALL) begin
            arm_cond  = sample > hi_th;
            fire_cond = sample <= level;
        end else begin
            arm_cond  = sample < lo_th;
            fire_cond = sample >= level;
        end
    end

    assign hit = valid && armed && fire_cond;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            armed <= 1'b0;
        end else if (clear || hit) begin
            armed <= 1'b0;
        end else if (valid && arm_cond) begin
            armed <= 1'b1;
        end
    end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Multi-channel trigger/capture engine: circular sample RAMs, acquisition
// FSM and a trigger-aligned random-access read port for the renderer.
module scope_capture_ctrl
    import scope_pkg::*;
#(
    parameter int  DATA_W  = 12,
    parameter int  NCH     = 2,
    parameter int  DEPTH   = 640,
    parameter int  AUTO_TO = 65536,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  CLK,
    input  logic                  RSTB,
    input  logic                  sample_valid,
    input  logic [NCH*DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0]     trig_level,
    input  logic [DATA_W-1:0]     trig_hyst,
    input  logic [CW-1:0]         trig_ch,
    input  logic                  trig_edge,
    input  logic [1:0]            mode,
    input  logic [AW-1:0]         pretrig,
    input  logic                  arm,
    input  logic [CW-1:0]         rd_ch,
    input  logic [AW-1:0]         rd_addr,
    input  logic                  rd_done,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  frame_ready,
    output logic                  trig_forced,
    output logic                  busy,
    output logic [2:0]            state
);

    localparam int           TW      = $clog2(AUTO_TO + 1);
    localparam logic [AW:0]  DEPTH_X = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

    state_t              st, nxt;
    logic [AW-1:0]       wp, cnt, fstart, pre_q, post_len;
    logic [AW-1:0]       pre_clamp, fs_calc, phys;
    logic [AW:0]         phys_sum;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   lvl_q, hyst_q, tsample;
    logic [CW-1:0]       ch_q, rd_ch_q;
    logic                edge_q, forced_q, rd_ok_q;
    logic [TW-1:0]       to_cnt;
    logic                accept, ld_cfg, eval, hit, force_trig, trig, is_auto;
    logic [NCH*DATA_W-1:0] rd_bus;

    assign busy        = (st == PRE_FILL) || (st == WAIT_TRIG) || (st == POST_FILL);
    assign accept      = sample_valid && busy;
    assign eval        = accept && (st == WAIT_TRIG);
    assign frame_ready = (st == DONE);
    assign state       = st;
    assign trig_forced = forced_q;
    assign pre_clamp   = (pretrig > LAST) ? LAST : pretrig;
    assign post_len    = LAST - pre_q;
    assign is_auto     = (mode_q == MODE_AUTO);
    assign force_trig  = eval && is_auto && (to_cnt == TW'(AUTO_TO - 1));
    assign trig        = hit || force_trig;
    assign fs_calc     = (wp >= pre_q) ? wp - pre_q
                       : AW'({1'b0, wp} + DEPTH_X - {1'b0, pre_q});

    always_comb begin
        tsample = sample_data[DATA_W-1:0];
        for (int c = 0; c < NCH; c++) begin
            if (ch_q == CW'(c)) tsample = sample_data[c*DATA_W +: DATA_W];
        end
    end

    scope_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .sample    (tsample),
        .level     (lvl_q),
        .hyst      (hyst_q),
        .trig_edge (edge_q),
        .valid     (eval),
        .clear     (ld_cfg),
        .hit       (hit)
    );

    always_comb begin
        nxt    = st;
        ld_cfg = 1'b0;
        unique case (st)
            IDLE: begin
                if (mode != MODE_SINGLE || arm) begin
                    nxt    = PRE_FILL;
                    ld_cfg = 1'b1;
                end
            end
            PRE_FILL: begin
                if (pre_q == '0) nxt = WAIT_TRIG;
                else if (accept && cnt == pre_q - AW'(1)) nxt = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (trig) nxt = (post_len == '0) ? DONE : POST_FILL;
            end
            POST_FILL: begin
                if (accept && cnt == post_len - AW'(1)) nxt = DONE;
            end
            DONE: begin
                if (rd_done) begin
                    if (mode_q == MODE_SINGLE) begin
                        nxt = IDLE;
                    end else begin
                        nxt    = PRE_FILL;
                        ld_cfg = 1'b1;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            st       <= IDLE;
            wp       <= '0;
            cnt      <= '0;
            to_cnt   <= '0;
            fstart   <= '0;
            pre_q    <= '0;
            mode_q   <= MODE_AUTO;
            lvl_q    <= '0;
            hyst_q   <= '0;
            ch_q     <= '0;
            edge_q   <= EDGE_RISE;
            forced_q <= 1'b0;
        end else begin
            st <= nxt;
            if (accept) wp <= (wp == LAST) ? '0 : wp + AW'(1);
            if (ld_cfg) begin
                mode_q   <= mode;
                pre_q    <= pre_clamp;
                lvl_q    <= trig_level;
                hyst_q   <= trig_hyst;
                ch_q     <= trig_ch;
                edge_q   <= trig_edge;
                cnt      <= '0;
                to_cnt   <= '0;
                forced_q <= 1'b0;
            end else begin
                if (st == WAIT_TRIG) cnt <= '0;
                else if (accept) cnt <= cnt + AW'(1);
                if (eval && is_auto) to_cnt <= to_cnt + TW'(1);
                // A real crossing on the timeout sample still counts as real
                if (trig) begin
                    forced_q <= !hit;
                    fstart   <= fs_calc;
                end
                if (st == DONE && rd_done) forced_q <= 1'b0;
            end
        end
    end

    assign phys_sum = {1'b0, fstart} + {1'b0, rd_addr};
    assign phys     = (phys_sum >= DEPTH_X) ? AW'(phys_sum - DEPTH_X)
                    : phys_sum[AW-1:0];

    for (genvar c = 0; c < NCH; c++) begin : g_ram
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] q;
        always_ff @(posedge CLK) begin
            if (accept) mem[wp] <= sample_data[c*DATA_W +: DATA_W];
            q <= mem[phys];
        end
        assign rd_bus[c*DATA_W +: DATA_W] = q;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            rd_ch_q <= '0;
            rd_ok_q <= 1'b0;
        end else begin
            rd_ch_q <= rd_ch;
            rd_ok_q <= (32'(rd_addr) < DEPTH) && (32'(rd_ch) < NCH);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_ok_q && rd_ch_q == CW'(c)) rd_data = rd_bus[c*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Self-checking bench for scope_capture_ctrl: directed frames plus
// randomized frames checked against a sample-stream reference model.
module tb_scope_capture_ctrl;

    localparam int DW = 12, NCH = 2, DEPTH = 16, AUTO_TO = 32;
    localparam int AW = 4, CW = 1;

    logic               CLK = 1'b0;
    logic               RSTB = 1'b0;
    logic               sample_valid = 1'b0;
    logic [NCH*DW-1:0]  sample_data = '0;
    logic [DW-1:0]      trig_level = '0, trig_hyst = '0;
    logic [CW-1:0]      trig_ch = '0, rd_ch = '0;
    logic               trig_edge = 1'b0, arm = 1'b0, rd_done = 1'b0;
    logic [1:0]         mode = 2'd1;
    logic [AW-1:0]      pretrig = '0, rd_addr = '0;
    logic [DW-1:0]      rd_data;
    logic               frame_ready, trig_forced, busy;
    logic [2:0]         state;

    int checks = 0, errors = 0;
    int smp [2][256];
    int md, pre, lvl, hys, tch, edg;

    typedef struct {
        int ch;
        int addr;
        int exp;
    } rdvec_t;

    scope_capture_ctrl #(
        .DATA_W(DW), .NCH(NCH), .DEPTH(DEPTH), .AUTO_TO(AUTO_TO)
    ) dut (
        .CLK(CLK), .RSTB(RSTB),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .trig_level(trig_level), .trig_hyst(trig_hyst),
        .trig_ch(trig_ch), .trig_edge(trig_edge),
        .mode(mode), .pretrig(pretrig), .arm(arm),
        .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_done(rd_done),
        .rd_data(rd_data), .frame_ready(frame_ready),
        .trig_forced(trig_forced), .busy(busy), .state(state)
    );

    always #10 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_cfg();
        mode       = 2'(md);
        pretrig    = AW'(pre);
        trig_level = DW'(lvl);
        trig_hyst  = DW'(hys);
        trig_ch    = CW'(tch);
        trig_edge  = 1'(edg);
        arm        = 1'b0;
        rd_done    = 1'b0;
    endtask

    task automatic scramble();
        mode       = 2'($urandom);
        pretrig    = AW'($urandom);
        trig_level = DW'($urandom);
        trig_hyst  = DW'($urandom);
        trig_ch    = CW'($urandom);
        trig_edge  = 1'($urandom);
        arm        = 1'($urandom);
        rd_done    = 1'($urandom);
    endtask

    task automatic do_reset();
        RSTB = 1'b0;
        sample_valid = 1'b0;
        apply_cfg();
        repeat (2) tick();
        RSTB = 1'b1;
        tick();
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic send(input int a, input int b);
        sample_valid = 1'b1;
        sample_data  = {DW'(b), DW'(a)};
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int ch, input int a, input int exp);
        rd_ch   = CW'(ch);
        rd_addr = AW'(a);
        tick();
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    // Feed smp[] until a frame is ready or maxn samples have gone in
    task automatic stream(input int maxn, input bit scr, output int cnt);
        cnt = 0;
        while (cnt < maxn) begin
            if (scr) scramble();
            send(smp[0][cnt], smp[1][cnt]);
            cnt++;
            if (frame_ready) break;
            repeat ($urandom_range(0, 2)) tick();
        end
        if (scr) apply_cfg();
    endtask

    task automatic next_frame();
        apply_cfg();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        settle();
    endtask

    // Index of the triggering sample within an uninterrupted stream
    function automatic void ref_frame(input int n, output int t, output bit forced);
        bit armed = 0;
        int lo, hi, v, to;
        lo = (lvl - hys < 0) ? 0 : lvl - hys;
        hi = (lvl + hys > 4095) ? 4095 : lvl + hys;
        to = 0;
        t = -1;
        forced = 0;
        for (int i = pre; i < n; i++) begin
            v = smp[tch][i];
            to++;
            if (armed && (edg ? v <= lvl : v >= lvl)) begin
                t = i;
                return;
            end
            if (md == 0 && to == AUTO_TO) begin
                t = i;
                forced = 1;
                return;
            end
            if (edg ? v > hi : v < lo) armed = 1;
        end
    endfunction

    initial begin
        rdvec_t t2[5];
        rdvec_t t3[4];
        int cnt, t, need, base;
        bit fr;

        t2[0] = '{0, 4, 100};
        t2[1] = '{0, 3, 99};
        t2[2] = '{0, 15, 111};
        t2[3] = '{0, 0, 96};
        t2[4] = '{1, 4, 1100};
        t3[0] = '{1, 0, 2000};
        t3[1] = '{1, 15, 1985};
        t3[2] = '{0, 0, 600};
        t3[3] = '{0, 15, 615};

        // reset held while every input toggles
        for (int i = 0; i < 8; i++) begin
            scramble();
            sample_valid = 1'($urandom);
            sample_data  = (NCH*DW)'($urandom);
            rd_ch        = CW'($urandom);
            rd_addr      = AW'($urandom);
            tick();
            chk("reset_outs", 32'({state, frame_ready, busy, trig_forced, rd_data}), 0);
        end

        md = 1; pre = 4; lvl = 100; hys = 8; tch = 0; edg = 0;
        for (int i = 0; i < 256; i++) begin
            smp[0][i] = 80 + i;
            smp[1][i] = 1080 + i;
        end
        do_reset();
        settle();
        stream(22, 0, cnt);
        chk("post_fill_state", 32'(state), 3);
        chk("post_fill_busy", 32'(busy), 1);
        #3 RSTB = 1'b0;
        #1 chk("async_reset", 32'({state, frame_ready, busy, trig_forced, rd_data}), 0);

        do_reset();
        settle();
        stream(100, 0, cnt);
        chk("t2_count", 32'(cnt), 32);
        chk("t2_ready", 32'(frame_ready), 1);
        chk("t2_forced", 32'(trig_forced), 0);
        for (int i = 0; i < 5; i++)
            rd_chk($sformatf("t2_rd%0d", i), t2[i].ch, t2[i].addr, t2[i].exp);

        md = 1; pre = 0; lvl = 2000; hys = 16; tch = 1; edg = 1;
        for (int i = 0; i < 256; i++) begin
            smp[0][i] = 500 + i;
            smp[1][i] = 2100 - i;
        end
        next_frame();
        stream(200, 0, cnt);
        chk("t3_count", 32'(cnt), 116);
        for (int i = 0; i < 4; i++)
            rd_chk($sformatf("t3_rd%0d", i), t3[i].ch, t3[i].addr, t3[i].exp);

        md = 1; pre = 0; lvl = 100; hys = 8; tch = 0; edg = 0;
        for (int i = 0; i < 256; i++) begin
            smp[0][i] = (i < 40) ? ((i % 2 == 0) ? 95 : 101)
                      : (i == 40) ? 91 : 60 + i;
            smp[1][i] = i;
        end
        next_frame();
        stream(200, 0, cnt);
        chk("hyst_count", 32'(cnt), 57);
        rd_chk("hyst_rd0", 0, 0, 101);
        rd_chk("hyst_rd1", 1, 0, 41);
        rd_chk("hyst_rd15", 0, 15, 116);

        md = 0; pre = 4; lvl = 100; hys = 8; tch = 0; edg = 0;
        for (int i = 0; i < 256; i++) begin
            smp[0][i] = 100;
            smp[1][i] = i;
        end
        next_frame();
        stream(200, 0, cnt);
        chk("auto_count", 32'(cnt), 47);
        chk("auto_forced", 32'(trig_forced), 1);
        rd_chk("auto_rd", 1, 4, 35);
        md = 1;
        next_frame();
        stream(200, 0, cnt);
        chk("normal_count", 32'(cnt), 200);
        chk("normal_noframe", 32'(frame_ready), 0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("rd_done_ignored", 32'(state), 2);

        md = 2; pre = 4; lvl = 100; hys = 8; tch = 0; edg = 0;
        for (int i = 0; i < 256; i++) begin
            smp[0][i] = 80 + i;
            smp[1][i] = 1080 + i;
        end
        do_reset();
        stream(100, 0, cnt);
        chk("single_idle_cnt", 32'(cnt), 100);
        chk("single_idle", 32'({state, frame_ready}), 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        settle();
        stream(100, 0, cnt);
        chk("single_count", 32'(cnt), 32);
        rd_chk("single_rd", 0, 4, 100);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_ignored", 32'(state), 4);
        rd_done = 1'b1;
        sample_valid = 1'b1;
        tick();
        rd_done = 1'b0;
        sample_valid = 1'b0;
        chk("single_done", 32'({state, frame_ready}), 0);

        for (int f = 0; f < 12; f++) begin
            md  = $urandom_range(0, 2);
            if (md == 2) md = 3;
            pre = $urandom_range(0, DEPTH - 1);
            lvl = $urandom_range(500, 3500);
            hys = $urandom_range(0, 300);
            tch = $urandom_range(0, 1);
            edg = $urandom_range(0, 1);
            for (int i = 0; i < 256; i++) begin
                smp[0][i] = $urandom_range(0, 4095);
                smp[1][i] = $urandom_range(0, 4095);
            end
            ref_frame(144, t, fr);
            if (t < 0) begin
                md = 0;
                ref_frame(144, t, fr);
            end
            need = t + DEPTH - pre;
            if (f == 0) begin
                do_reset();
                settle();
            end else begin
                apply_cfg();
                rd_done = 1'b1;
                sample_valid = 1'b1;
                sample_data = (NCH*DW)'($urandom);
                tick();
                rd_done = 1'b0;
                sample_valid = 1'b0;
                chk($sformatf("rnd%0d_release", f), 32'(frame_ready), 0);
                settle();
            end
            stream(200, 1, cnt);
            chk($sformatf("rnd%0d_count", f), 32'(cnt), 32'(need));
            chk($sformatf("rnd%0d_forced", f), 32'(trig_forced), 32'(fr));
            send($urandom_range(0, 4095), $urandom_range(0, 4095));
            send($urandom_range(0, 4095), $urandom_range(0, 4095));
            base = t - pre;
            for (int ch = 0; ch < NCH; ch++)
                for (int a = 0; a < DEPTH; a++)
                    rd_chk($sformatf("rnd%0d_c%0d_a%0d", f, ch, a), ch, a, smp[ch][base + a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
Parametrised multi-channel trigger and capture engine for the oscilloscope datapath. It sits between the ADC sample stream and the VGA waveform renderer, and replaces the single-channel FIFO and trigger path. It provides programmable pre-trigger depth, edge/level trigger with hysteresis, and auto/normal/single acquisition modes. A trigger-aligned frame is presented to the display through a random-access read port.

Parameters:
DATA_W, 12, sample width (ADC resolution)
NCH, 2, number of input channels
DEPTH, 640, samples per channel per frame (one per VGA column)
AUTO_TO, 65536, auto-mode timeout in accepted samples
AW, $clog2(DEPTH), address width (derived, not overridable)
CW, max(1,$clog2(NCH)), channel-select width (derived)

Ports:
CLK  in  1  system clock (50 MHz)
RSTB  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe per ADC conversion (ADC_CLK-derived, synchronous to CLK)
sample_data  in  NCH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
trig_level  in  DATA_W  trigger threshold (from trigger_adjust TRIG)
trig_hyst  in  DATA_W  hysteresis band
trig_ch  in  CW  trigger source channel
trig_edge  in  1  0 = rising, 1 = falling
mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = reserved (treated as normal)
pretrig  in  AW  samples kept before the trigger point
arm  in  1  single-mode arm pulse
rd_ch  in  CW  display read channel
rd_addr  in  AW  display column, 0 = oldest sample of the frame
rd_done  in  1  display finished with frame (pulse)
rd_data  out  DATA_W  sample at (rd_ch, rd_addr); 1-cycle latency
frame_ready  out  1  trigger-aligned frame valid and frozen
trig_forced  out  1  current frame was captured by auto timeout
busy  out  1  acquisition in progress (PRE_FILL, WAIT_TRIG, POST_FILL)
state  out  3  FSM state code, for debug and LED use

Behaviour:
- Reset (async assert, sync release): state = IDLE; rd_data, frame_ready, trig_forced, busy = 0; write pointer, all counters and the hysteresis arm flag = 0. RAM contents are not reset.
- Storage: NCH simple dual-port RAMs of DEPTH x DATA_W. Write pointer wp wraps DEPTH-1 -> 0. Every accepted sample writes all channels at wp, then wp advances.
- A sample is accepted only when sample_valid = 1 and state is PRE_FILL, WAIT_TRIG or POST_FILL.
- Latched configuration:
  - mode, pretrig (clamped to DEPTH-1), trig_* are latched on entry to PRE_FILL.
  - Changes mid-acquisition take effect on the next frame.
- FSM states:
  - IDLE (0):
    - If mode is not single, go to PRE_FILL next cycle.
    - If mode is single, wait for arm.
  - PRE_FILL (1):
    - Count accepted samples.
    - After pretrig samples, go to WAIT_TRIG.
    - pretrig = 0 skips straight to WAIT_TRIG.
  - WAIT_TRIG (2):
    - Each accepted sample on trig_ch is evaluated.
    - Rising edge: the arm flag sets when sample < level-hyst (saturating at 0); the trigger fires when the arm flag is set and sample >= level.
    - Falling edge: mirror of rising, using level+hyst (saturating at 2^DATA_W-1).
    - The arm flag clears on the trigger and on PRE_FILL entry.
    - Auto timeout: in auto mode, a timeout counter increments per accepted sample; reaching AUTO_TO forces the trigger and sets trig_forced.
    - If a real trigger and the timeout coincide on the same sample, the real trigger wins and trig_forced = 0.
    - The triggering sample is written at address t; frame_start = (t - pretrig) mod DEPTH.
  - POST_FILL (3):
    - Accept DEPTH-1-pretrig further samples, then go to DONE.
  - DONE (4):
    - frame_ready = 1 and writes stop (incoming samples are dropped).
    - On rd_done: frame_ready drops next cycle; single mode goes to IDLE, otherwise to PRE_FILL.
    - When rd_done coincides with sample_valid, that sample is dropped.
- Read address mapping: physical address = (frame_start + rd_addr) mod DEPTH, computed without a divider (compare-and-subtract).
- Read port behaviour:
  - rd_addr >= DEPTH returns 0.
  - Reads are legal in any state; data is only meaningful while frame_ready = 1.
- busy = 1 exactly in states 1-3.
- arm outside IDLE is ignored.
- rd_done outside DONE is ignored.

Decomposition:
- Package scope_pkg:
  - state enum (IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, DONE)
  - mode constants (MODE_AUTO, MODE_NORMAL, MODE_SINGLE)
  - edge constants (EDGE_RISE, EDGE_FALL)
- One sub-module, scope_trig_detect:
  - inputs: sample, level, hyst, edge, valid, clear
  - output: one-cycle hit
  - owns the hysteresis arm flag and the saturating threshold arithmetic.
- RAM is inferred inline (generate loop over NCH).

Test Plan:
All scenarios use DATA_W=12, NCH=2, DEPTH=16, AUTO_TO=32.
1. Reset with all inputs toggling -> state=0, frame_ready=0, busy=0, rd_data=0. Assert RSTB low during POST_FILL -> all outputs return to 0 immediately.
2. Normal mode, rising edge, trig_ch=0, level=100, hyst=8, pretrig=4; ch0 ramps 80,81,... -> frame_ready=1 and trig_forced=0. Reading (ch0, addr 4) returns 100, addr 3 returns 99, addr 15 returns 111.
3. Falling edge on ch1, level=2000, hyst=16, pretrig=0; ch1 ramps down from 2100 -> (ch1, addr 0) returns 2000. Ch0 data at the same addresses comes from the same sample instants.
4. Auto mode, constant input 100, level=100, pretrig=4 -> frame_ready after 4+32+11 accepted samples, with trig_forced=1. Normal mode with the same stimulus -> no frame after 200 samples.
5. Hysteresis: noise alternating 95/101, level=100, hyst=8 -> no trigger. A dip to 91, then 101 -> trigger at the 101 sample.
6. Single mode without arm -> state stays 0 for 100 samples. Pulse arm -> one frame captured. rd_done -> state returns to 0 and frame_ready=0 next cycle. rd_done in the same cycle as sample_valid -> sample dropped, wp unchanged.
